// File: rtl/aes_ciphertext_sink.sv
// aes_ciphertext_sink: buffers one 128-bit AES ciphertext block and writes it to TCDM as four 32-bit words.
// Define AES_SINK_BSWAP_EN to store each block byte-reversed (big-endian AES byte order in memory).
module aes_ciphertext_sink #(
    parameter int BLK_W = 128,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             req_start_i,
    input  logic [31:0]      base_addr_i,
    input  logic [CNT_W-1:0] trans_size_i,
    output logic             ready_start_o,
    output logic             done_o,
    output logic             busy_o,
    input  logic             stream_valid_i,
    input  logic [BLK_W-1:0] stream_data_i,
    output logic             stream_ready_o,
    output logic             tcdm_req_o,
    input  logic             tcdm_gnt_i,
    output logic [31:0]      tcdm_add_o,
    output logic             tcdm_wen_o,
    output logic [3:0]       tcdm_be_o,
    output logic [31:0]      tcdm_data_o
);
    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
    state_t state, state_nxt;
    logic [31:0] base;
    logic [CNT_W-1:0] size, blk_cnt;
    logic [1:0] word_idx;
    logic [BLK_W-1:0] blk_buf, blk_in;
    logic last_word, last_blk;

`ifdef AES_SINK_BSWAP_EN
    always_comb begin
        blk_in = '0;
        for (int i = 0; i < BLK_W/8; i++) blk_in[8*i +: 8] = stream_data_i[BLK_W-8-8*i +: 8];
    end
`else
    assign blk_in = stream_data_i;
`endif

    assign last_word = word_idx == 2'd3;
    assign last_blk  = blk_cnt == size - 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) state_nxt = IDLE;
        else begin
            case (state)
                IDLE:    if (req_start_i) state_nxt = (trans_size_i == '0) ? DONE : ACCEPT;
                ACCEPT:  if (stream_valid_i) state_nxt = WRITE;
                WRITE:   if (tcdm_gnt_i && last_word) state_nxt = last_blk ? DONE : ACCEPT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base     <= '0;
            size     <= '0;
            blk_cnt  <= '0;
            word_idx <= '0;
            blk_buf  <= '0;
        end else if (clear) begin
            blk_cnt  <= '0;
            word_idx <= '0;
            blk_buf  <= '0;
        end else if (state == IDLE && req_start_i) begin
            base     <= base_addr_i;
            size     <= trans_size_i;
            blk_cnt  <= '0;
            word_idx <= '0;
        end else if (state == ACCEPT && stream_valid_i) begin
            blk_buf  <= blk_in;
            word_idx <= '0;
        end else if (state == WRITE && tcdm_gnt_i) begin
            word_idx <= word_idx + 2'd1;
            if (last_word && !last_blk) blk_cnt <= blk_cnt + 1'b1;
        end
    end

    // Address and data are forced to zero outside WRITE so idle outputs match the reset values.
    assign ready_start_o  = state == IDLE;
    assign stream_ready_o = state == ACCEPT;
    assign tcdm_req_o     = state == WRITE;
    assign busy_o         = stream_ready_o || tcdm_req_o;
    assign done_o         = state == DONE;
    assign tcdm_wen_o     = 1'b0;
    assign tcdm_be_o      = 4'hF;
    assign tcdm_add_o     = tcdm_req_o ? base + 32'({blk_cnt, 4'b0}) + {28'd0, word_idx, 2'b0} : '0;
    assign tcdm_data_o    = tcdm_req_o ? blk_buf[32*word_idx +: 32] : '0;
endmodule

// File: tb/tb_aes_ciphertext_sink.sv
// tb_aes_ciphertext_sink: scoreboard bench for aes_ciphertext_sink.
module tb_aes_ciphertext_sink;
    logic clk = 0, reset_n = 0, clear = 0, req_start_i = 0;
    logic [31:0] base_addr_i = 0;
    logic [15:0] trans_size_i = 0;
    logic ready_start_o, done_o, busy_o, stream_ready_o, tcdm_req_o, tcdm_wen_o;
    logic stream_valid_i = 0, tcdm_gnt_i = 0;
    logic [127:0] stream_data_i = 0;
    logic [31:0] tcdm_add_o, tcdm_data_o;
    logic [3:0] tcdm_be_o;

    aes_ciphertext_sink dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .req_start_i(req_start_i), .base_addr_i(base_addr_i), .trans_size_i(trans_size_i),
        .ready_start_o(ready_start_o), .done_o(done_o), .busy_o(busy_o),
        .stream_valid_i(stream_valid_i), .stream_data_i(stream_data_i), .stream_ready_o(stream_ready_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [63:0] sb_q[$];
    logic [127:0] blk_q[$];
    int stall = 0, gnt_budget = -1, wait_cnt = 0;
    bit spurious = 0, hs_seen = 0, stalled = 0;
    logic [63:0] held = 0;
    int done_cnt = 0, req_cyc = 0, srdy_cyc = 0;
    logic [31:0] w [4];
    localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] d, input int i);
        logic [127:0] b = d;
`ifdef AES_SINK_BSWAP_EN
        for (int k = 0; k < 16; k++) b[8*k +: 8] = d[8*(15-k) +: 8];
`endif
        return b[32*i +: 32];
    endfunction

    task automatic push_blk(input logic [31:0] base, input int idx, input logic [127:0] d);
        for (int i = 0; i < 4; i++) sb_q.push_back({base + 32'(16*idx) + 32'(4*i), word_of(d, i)});
        blk_q.push_back(d);
    endtask

    // Runs one transfer from IDLE; lat is the cycle (start = cycle 0) on which done_o was seen.
    task automatic start(input string tag, input logic [31:0] base, input logic [15:0] size, output int lat);
        bit seen = 0;
        int n = 0;
        while (!ready_start_o && n < 200) begin @(posedge clk); #1; n++; end
        req_start_i = 1; base_addr_i = base; trans_size_i = size;
        lat = 0;
        while (!seen && lat < 2000) begin
            @(posedge clk); #1; req_start_i = 0; lat++;
            @(negedge clk); seen = done_o;
        end
        check({tag, "_done_seen"}, 64'(seen), 1);
        check({tag, "_sb_drained"}, 64'(sb_q.size()), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) hs_seen = stream_valid_i && stream_ready_o;

    always @(posedge clk) begin
        #1;
        if (hs_seen && blk_q.size() > 0) void'(blk_q.pop_front());
        stream_valid_i = blk_q.size() > 0;
        stream_data_i = (blk_q.size() > 0) ? blk_q[0] : '0;
    end

    always @(posedge clk) begin
        #1;
        if (!tcdm_req_o) begin
            tcdm_gnt_i = spurious; wait_cnt = 0;
        end else if (gnt_budget != 0 && wait_cnt >= stall) begin
            tcdm_gnt_i = 1; wait_cnt = 0;
            if (gnt_budget > 0) gnt_budget--;
        end else begin
            tcdm_gnt_i = 0; wait_cnt++;
        end
    end

    always @(negedge clk) begin
        if (done_o) done_cnt++;
        if (tcdm_req_o) req_cyc++;
        if (stream_ready_o) srdy_cyc++;
        if (stalled && reset_n) begin
            check("stall_req", 64'(tcdm_req_o), 1);
            check("stall_word", {tcdm_add_o, tcdm_data_o}, held);
        end
        if (tcdm_req_o) check("wen_be", {59'd0, tcdm_wen_o, tcdm_be_o}, 64'hF);
        if (tcdm_req_o && tcdm_gnt_i) begin
            check("write_expected", 64'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) check("tcdm_write", {tcdm_add_o, tcdm_data_o}, sb_q.pop_front());
        end
        stalled = tcdm_req_o && !tcdm_gnt_i && !clear && reset_n;
        held = {tcdm_add_o, tcdm_data_o};
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, d0, r0, s0, n;
        #1;
        check("rst_flags", {58'd0, ready_start_o, done_o, busy_o, stream_ready_o, tcdm_req_o, tcdm_wen_o}, 64'h20);
        check("rst_bus", {tcdm_add_o, tcdm_data_o}, 0);
        check("rst_be", 64'(tcdm_be_o), 64'hF);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;

`ifdef AES_SINK_BSWAP_EN
        w = '{32'h33221100, 32'h77665544, 32'hBBAA9988, 32'hFFEEDDCC};
`else
        w = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
`endif
        for (int i = 0; i < 4; i++) sb_q.push_back({32'h1000_0000 + 32'(4*i), w[i]});
        blk_q.push_back(D1);
        start("single", 32'h1000_0000, 1, lat);
        check("single_latency", 64'(lat), 6);

        stall = 2; spurious = 1; d0 = done_cnt;
        for (int b = 0; b < 3; b++) push_blk(32'h2000_0000, b, {$urandom, $urandom, $urandom, $urandom});
        start("stall3", 32'h2000_0000, 3, lat);
        check("stall3_latency", 64'(lat), 40);
        check("stall3_one_done", 64'(done_cnt - d0), 1);
        stall = 0; spurious = 0;

        r0 = req_cyc; s0 = srdy_cyc;
        start("size0", 32'h5000_0000, 0, lat);
        check("size0_latency", 64'(lat), 1);
        check("size0_no_req", 64'(req_cyc - r0), 0);
        check("size0_no_ready", 64'(srdy_cyc - s0), 0);

        push_blk(32'hFFFF_FFF8, 0, {$urandom, $urandom, $urandom, $urandom});
        start("wrap", 32'hFFFF_FFF8, 1, lat);
        check("wrap_latency", 64'(lat), 6);

        req_start_i = 1; base_addr_i = 0; trans_size_i = 0;
        @(posedge clk); #1; @(negedge clk); check("donecyc_c1", 64'(done_o), 1);
        @(posedge clk); #1; @(negedge clk); check("donecyc_c2", 64'(done_o), 0);
        @(posedge clk); #1; req_start_i = 0; @(negedge clk); check("donecyc_c3", 64'(done_o), 1);
        @(posedge clk); #1;

        gnt_budget = 2;
        push_blk(32'h3000_0000, 0, {$urandom, $urandom, $urandom, $urandom});
        req_start_i = 1; base_addr_i = 32'h3000_0000; trans_size_i = 1;
        @(posedge clk); #1; req_start_i = 0;
        n = 0;
        while (tcdm_add_o != 32'h3000_0008 && n < 50) begin @(posedge clk); #1; n++; end
        check("clr_at_word2", 64'(tcdm_add_o), 64'h3000_0008);
        req_start_i = 1; base_addr_i = 32'h4000_0000;
        @(posedge clk); #1; req_start_i = 0;
        d0 = done_cnt;
        clear = 1;
        @(posedge clk); #1; clear = 0;
        @(negedge clk);
        check("clr_req_drop", 64'(tcdm_req_o), 0);
        check("clr_ready", 64'(ready_start_o), 1);
        repeat (3) @(posedge clk);
        #1;
        check("clr_no_done", 64'(done_cnt - d0), 0);
        check("clr_words_left", 64'(sb_q.size()), 2);
        sb_q.delete();
        gnt_budget = -1;
        push_blk(32'h3000_0100, 0, D1);
        start("after_clr", 32'h3000_0100, 1, lat);
        check("after_clr_latency", 64'(lat), 6);

        gnt_budget = 1;
        push_blk(32'h6000_0000, 0, D1);
        req_start_i = 1; base_addr_i = 32'h6000_0000; trans_size_i = 2;
        @(posedge clk); #1; req_start_i = 0;
        n = 0;
        while (tcdm_add_o != 32'h6000_0004 && n < 50) begin @(posedge clk); #1; n++; end
        #2 reset_n = 0;
        #1;
        check("midrst_flags", {59'd0, ready_start_o, done_o, busy_o, stream_ready_o, tcdm_req_o}, 64'h10);
        check("midrst_bus", {tcdm_add_o, tcdm_data_o}, 0);
        sb_q.delete();
        @(posedge clk); #1 reset_n = 1;
        gnt_budget = -1;
        push_blk(32'h7000_0000, 0, D1);
        start("after_rst", 32'h7000_0000, 1, lat);
        check("after_rst_latency", 64'(lat), 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
